// File: rtl/snake_renderer_pkg.sv
// Shared game constants for the snake pixel renderer: grid geometry,
// colour palette and the encoding of the snapshot FSM states.
package snake_renderer_pkg;

   localparam int CELL_SHIFT = 3;
   localparam int GRID_W     = 80;
   localparam int GRID_H     = 60;
   localparam int CELL_BITS  = 7;

   // Colours are packed {R, G, B}, 4 bits each
   localparam logic [11:0] COL_HEAD      = 12'h0F0;
   localparam logic [11:0] COL_HEAD_DEAD = 12'hF00;
   localparam logic [11:0] COL_BODY      = 12'h0A0;
   localparam logic [11:0] COL_FRUIT     = 12'hF00;
   localparam logic [11:0] COL_BORDER    = 12'h888;
   localparam logic [11:0] COL_BG        = 12'h000;

   typedef enum logic [1:0] {
      SNAP_IDLE  = 2'd0,
      SNAP_FETCH = 2'd1,
      SNAP_DRAIN = 2'd2
   } snap_state_e;

   // True when two grid cells coincide
   function automatic logic cell_match(input logic [CELL_BITS-1:0] ax,
                                       input logic [CELL_BITS-1:0] ay,
                                       input logic [CELL_BITS-1:0] bx,
                                       input logic [CELL_BITS-1:0] by);
      return (ax == bx) && (ay == by);
   endfunction

endpackage

// File: rtl/snake_body_snapshot.sv
// Per-frame snapshot of the game state. Head, fruit, length and collision
// are latched on frame_tik; body segments are then fetched one per cycle
// into shadow registers and copied to the active set in a single commit,
// so the renderer never sees a half-updated snake.
module snake_body_snapshot
   import snake_renderer_pkg::*;
#(
   parameter  int SNAKE_LENGTH_BIT = 4,
   localparam int BODY_N           = (2 ** SNAKE_LENGTH_BIT) - 2
) (
   input  logic                          clock_25,
   input  logic                          reset,
   input  logic                          frame_tik,
   input  logic [CELL_BITS-1:0]          snake_head_x,
   input  logic [CELL_BITS-1:0]          snake_head_y,
   input  logic [CELL_BITS-1:0]          fruit_x,
   input  logic [CELL_BITS-1:0]          fruit_y,
   input  logic [SNAKE_LENGTH_BIT-1:0]   snake_length,
   input  logic                          collision_detected,
   input  logic [CELL_BITS-1:0]          snake_body_x,
   input  logic [CELL_BITS-1:0]          snake_body_y,
   output logic [SNAKE_LENGTH_BIT-1:0]   body_index,
   output logic [CELL_BITS-1:0]          head_x_r,
   output logic [CELL_BITS-1:0]          head_y_r,
   output logic [CELL_BITS-1:0]          fruit_x_r,
   output logic [CELL_BITS-1:0]          fruit_y_r,
   output logic                          dead_r,
   output logic                          snapshot_valid_r,
   output logic [BODY_N-1:0]             valid_mask_r,
   output logic [BODY_N*CELL_BITS-1:0]   body_x_r,
   output logic [BODY_N*CELL_BITS-1:0]   body_y_r
);

   snap_state_e                 state_r;
   logic [CELL_BITS-1:0]        sh_head_x_r;
   logic [CELL_BITS-1:0]        sh_head_y_r;
   logic [CELL_BITS-1:0]        sh_fruit_x_r;
   logic [CELL_BITS-1:0]        sh_fruit_y_r;
   logic                        sh_dead_r;
   logic [SNAKE_LENGTH_BIT-1:0] sh_len_r;
   logic [CELL_BITS-1:0]        sh_body_x_r [BODY_N];
   logic [CELL_BITS-1:0]        sh_body_y_r [BODY_N];

   // Snapshot FSM: latch on frame_tik (which also aborts a fetch in flight),
   // fetch body entries serially, then commit shadow to active in one cycle
   always_ff @(posedge clock_25) begin
      if (reset) begin
         state_r          <= SNAP_IDLE;
         body_index       <= '0;
         sh_head_x_r      <= '0;
         sh_head_y_r      <= '0;
         sh_fruit_x_r     <= '0;
         sh_fruit_y_r     <= '0;
         sh_dead_r        <= 1'b0;
         sh_len_r         <= '0;
         head_x_r         <= '0;
         head_y_r         <= '0;
         fruit_x_r        <= '0;
         fruit_y_r        <= '0;
         dead_r           <= 1'b0;
         snapshot_valid_r <= 1'b0;
         valid_mask_r     <= '0;
         body_x_r         <= '0;
         body_y_r         <= '0;
         for (int i = 0; i < BODY_N; i++) begin
            sh_body_x_r[i] <= '0;
            sh_body_y_r[i] <= '0;
         end
      end else if (frame_tik) begin
         sh_head_x_r  <= snake_head_x;
         sh_head_y_r  <= snake_head_y;
         sh_fruit_x_r <= fruit_x;
         sh_fruit_y_r <= fruit_y;
         sh_dead_r    <= collision_detected;
         sh_len_r     <= snake_length;
         body_index   <= '0;
         if (snake_length >= SNAKE_LENGTH_BIT'(2)) begin
            state_r <= SNAP_FETCH;
         end else begin
            // Head-only snake: nothing to fetch, commit straight from the inputs
            state_r          <= SNAP_IDLE;
            head_x_r         <= snake_head_x;
            head_y_r         <= snake_head_y;
            fruit_x_r        <= fruit_x;
            fruit_y_r        <= fruit_y;
            dead_r           <= collision_detected;
            valid_mask_r     <= '0;
            snapshot_valid_r <= 1'b1;
         end
      end else begin
         case (state_r)
            SNAP_IDLE: begin
               body_index <= '0;
            end
            SNAP_FETCH: begin
               // Data on snake_body_x/y answers the index issued last cycle
               if (body_index != '0) begin
                  sh_body_x_r[body_index - SNAKE_LENGTH_BIT'(1)] <= snake_body_x;
                  sh_body_y_r[body_index - SNAKE_LENGTH_BIT'(1)] <= snake_body_y;
               end
               if (body_index == sh_len_r - SNAKE_LENGTH_BIT'(2)) begin
                  state_r <= SNAP_DRAIN;
               end else begin
                  body_index <= body_index + SNAKE_LENGTH_BIT'(1);
               end
            end
            SNAP_DRAIN: begin
               // The last entry arrives this cycle and goes straight to active
               for (int i = 0; i < BODY_N; i++) begin
                  if (SNAKE_LENGTH_BIT'(i) == body_index) begin
                     body_x_r[i*CELL_BITS +: CELL_BITS] <= snake_body_x;
                     body_y_r[i*CELL_BITS +: CELL_BITS] <= snake_body_y;
                  end else begin
                     body_x_r[i*CELL_BITS +: CELL_BITS] <= sh_body_x_r[i];
                     body_y_r[i*CELL_BITS +: CELL_BITS] <= sh_body_y_r[i];
                  end
                  valid_mask_r[i] <= (SNAKE_LENGTH_BIT'(i + 1) < sh_len_r);
               end
               sh_body_x_r[body_index] <= snake_body_x;
               sh_body_y_r[body_index] <= snake_body_y;
               head_x_r         <= sh_head_x_r;
               head_y_r         <= sh_head_y_r;
               fruit_x_r        <= sh_fruit_x_r;
               fruit_y_r        <= sh_fruit_y_r;
               dead_r           <= sh_dead_r;
               snapshot_valid_r <= 1'b1;
               body_index       <= '0;
               state_r          <= SNAP_IDLE;
            end
            default: begin
               state_r    <= SNAP_IDLE;
               body_index <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/snake_renderer.sv
// Pixel-colour stage for the snake game. Two-stage pipeline: stage 1
// registers the grid cell and syncs, stage 2 resolves the colour priority
// against the committed snapshot and registers RGB with the delayed syncs.
module snake_renderer
   import snake_renderer_pkg::*;
#(
   parameter int PIXEL_DISPLAY_BIT = 9,
   parameter int SNAKE_LENGTH_BIT  = 4,
   parameter int GRID_W            = snake_renderer_pkg::GRID_W,
   parameter int GRID_H            = snake_renderer_pkg::GRID_H
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic [PIXEL_DISPLAY_BIT:0]  X,
   input  logic [PIXEL_DISPLAY_BIT:0]  Y,
   input  logic                        display_area,
   input  logic                        h_sync,
   input  logic                        v_sync,
   input  logic                        frame_tik,
   input  logic [6:0]                  snake_head_x,
   input  logic [6:0]                  snake_head_y,
   input  logic [6:0]                  fruit_x,
   input  logic [6:0]                  fruit_y,
   input  logic [SNAKE_LENGTH_BIT-1:0] snake_length,
   input  logic                        collision_detected,
   output logic [SNAKE_LENGTH_BIT-1:0] body_index,
   input  logic [6:0]                  snake_body_x,
   input  logic [6:0]                  snake_body_y,
   output logic [3:0]                  VGA_R,
   output logic [3:0]                  VGA_G,
   output logic [3:0]                  VGA_B,
   output logic                        VGA_HS,
   output logic                        VGA_VS
);

   localparam int BODY_N = (2 ** SNAKE_LENGTH_BIT) - 2;
   localparam logic [CELL_BITS-1:0] grid_w_c    = CELL_BITS'(GRID_W);
   localparam logic [CELL_BITS-1:0] grid_h_c    = CELL_BITS'(GRID_H);
   localparam logic [CELL_BITS-1:0] grid_w_m1_c = CELL_BITS'(GRID_W - 1);
   localparam logic [CELL_BITS-1:0] grid_h_m1_c = CELL_BITS'(GRID_H - 1);

   logic [CELL_BITS-1:0]        head_x_s, head_y_s, fruit_x_s, fruit_y_s;
   logic                        dead_s, snapshot_valid_s;
   logic [BODY_N-1:0]           valid_mask_s;
   logic [BODY_N*CELL_BITS-1:0] body_x_s, body_y_s;

   logic [CELL_BITS-1:0] cx_r, cy_r;
   logic                 de_r, hs_r, vs_r;
   logic                 head_hit_s, body_hit_s, fruit_hit_s, border_s;
   logic [11:0]          colour_s;
   logic                 unused_low_bits_s;

   // Sub-cell pixel bits are intentionally ignored
   assign unused_low_bits_s = ^{X[CELL_SHIFT-1:0], Y[CELL_SHIFT-1:0]};

   snake_body_snapshot #(
      .SNAKE_LENGTH_BIT (SNAKE_LENGTH_BIT)
   ) u_snapshot (
      .clock_25           (clock_25),
      .reset              (reset),
      .frame_tik          (frame_tik),
      .snake_head_x       (snake_head_x),
      .snake_head_y       (snake_head_y),
      .fruit_x            (fruit_x),
      .fruit_y            (fruit_y),
      .snake_length       (snake_length),
      .collision_detected (collision_detected),
      .snake_body_x       (snake_body_x),
      .snake_body_y       (snake_body_y),
      .body_index         (body_index),
      .head_x_r           (head_x_s),
      .head_y_r           (head_y_s),
      .fruit_x_r          (fruit_x_s),
      .fruit_y_r          (fruit_y_s),
      .dead_r             (dead_s),
      .snapshot_valid_r   (snapshot_valid_s),
      .valid_mask_r       (valid_mask_s),
      .body_x_r           (body_x_s),
      .body_y_r           (body_y_s)
   );

   // Stage 1: reduce pixel coordinates to a grid cell, carry syncs along
   always_ff @(posedge clock_25) begin
      if (reset) begin
         cx_r <= '0;
         cy_r <= '0;
         de_r <= 1'b0;
         hs_r <= 1'b0;
         vs_r <= 1'b0;
      end else begin
         cx_r <= X[PIXEL_DISPLAY_BIT:CELL_SHIFT];
         cy_r <= Y[PIXEL_DISPLAY_BIT:CELL_SHIFT];
         de_r <= display_area;
         hs_r <= h_sync;
         vs_r <= v_sync;
      end
   end

   // Stage 2 compares and colour priority: head > body > fruit > border > bg
   always_comb begin
      head_hit_s  = snapshot_valid_s & cell_match(cx_r, cy_r, head_x_s, head_y_s);
      fruit_hit_s = snapshot_valid_s & cell_match(cx_r, cy_r, fruit_x_s, fruit_y_s);
      body_hit_s  = 1'b0;
      for (int i = 0; i < BODY_N; i++) begin
         body_hit_s = body_hit_s | (valid_mask_s[i] &
                      cell_match(cx_r, cy_r, body_x_s[i*CELL_BITS +: CELL_BITS],
                                 body_y_s[i*CELL_BITS +: CELL_BITS]));
      end
      body_hit_s = body_hit_s & snapshot_valid_s;
      border_s   = (cx_r < grid_w_c) && (cy_r < grid_h_c) &&
                   ((cx_r == 7'd0) || (cx_r == grid_w_m1_c) ||
                    (cy_r == 7'd0) || (cy_r == grid_h_m1_c));
      if (!de_r) begin
         colour_s = COL_BG;
      end else if (head_hit_s) begin
         colour_s = dead_s ? COL_HEAD_DEAD : COL_HEAD;
      end else if (body_hit_s) begin
         colour_s = COL_BODY;
      end else if (fruit_hit_s) begin
         colour_s = COL_FRUIT;
      end else if (border_s) begin
         colour_s = COL_BORDER;
      end else begin
         colour_s = COL_BG;
      end
   end

   // Stage 2 register: colour and syncs leave together, two cycles after input
   always_ff @(posedge clock_25) begin
      if (reset) begin
         VGA_R  <= 4'h0;
         VGA_G  <= 4'h0;
         VGA_B  <= 4'h0;
         VGA_HS <= 1'b0;
         VGA_VS <= 1'b0;
      end else begin
         VGA_R  <= colour_s[11:8];
         VGA_G  <= colour_s[7:4];
         VGA_B  <= colour_s[3:0];
         VGA_HS <= hs_r;
         VGA_VS <= vs_r;
      end
   end

endmodule

// File: tb/tb_snake_renderer.sv
// Scoreboard bench for snake_renderer: every cycle the expected colour and
// syncs are pushed when the pixel is driven and popped two cycles later.
module tb_snake_renderer;

   logic       clock_25 = 1'b0;
   logic       reset;
   logic [9:0] X, Y;
   logic       display_area, h_sync, v_sync, frame_tik;
   logic [6:0] snake_head_x, snake_head_y, fruit_x, fruit_y;
   logic [3:0] snake_length;
   logic       collision_detected;
   logic [3:0] body_index;
   logic [6:0] snake_body_x, snake_body_y;
   logic [3:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_HS, VGA_VS;

   typedef struct packed {
      logic [11:0] rgb;
      logic [1:0]  sync;
   } sb_item_t;

   sb_item_t   sb_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   // upstream body table (answers body_index one cycle later)
   logic [6:0] tb_bx [16];
   logic [6:0] tb_by [16];
   logic [3:0] prev_bi;

   // reference model of the committed snapshot
   bit m_valid, m_dead, p_dead, m_busy;
   int m_hx, m_hy, m_fx, m_fy, m_n;
   int p_hx, p_hy, p_fx, p_fy, p_len, m_k;
   int m_bx [14], m_by [14], p_bx [14], p_by [14];
   int exp_bi;

   always #5 clock_25 = ~clock_25;

   snake_renderer dut (
      .clock_25(clock_25), .reset(reset), .X(X), .Y(Y),
      .display_area(display_area), .h_sync(h_sync), .v_sync(v_sync),
      .frame_tik(frame_tik), .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
      .fruit_x(fruit_x), .fruit_y(fruit_y), .snake_length(snake_length),
      .collision_detected(collision_detected), .body_index(body_index),
      .snake_body_x(snake_body_x), .snake_body_y(snake_body_y),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] model_col(input int x, input int y);
      int cx, cy;
      bit on_body;
      cx = x / 8;
      cy = y / 8;
      on_body = 1'b0;
      for (int i = 0; i < m_n; i++)
         if (m_bx[i] == cx && m_by[i] == cy) on_body = 1'b1;
      if (m_valid && cx == m_hx && cy == m_hy) return m_dead ? 12'hF00 : 12'h0F0;
      if (m_valid && on_body) return 12'h0A0;
      if (m_valid && cx == m_fx && cy == m_fy) return 12'hF00;
      if (cx < 80 && cy < 60 && (cx == 0 || cx == 79 || cy == 0 || cy == 59)) return 12'h888;
      return 12'h000;
   endfunction

   task automatic model_commit();
      m_valid = 1'b1;
      m_hx = p_hx; m_hy = p_hy; m_fx = p_fx; m_fy = p_fy; m_dead = p_dead;
      m_n = (p_len > 1) ? p_len - 1 : 0;
      for (int i = 0; i < 14; i++) begin
         m_bx[i] = p_bx[i];
         m_by[i] = p_by[i];
      end
   endtask

   // advance the model over the clock edge that follows the current drive
   task automatic model_edge(input logic tik);
      if (tik) begin
         p_hx = int'(snake_head_x); p_hy = int'(snake_head_y);
         p_fx = int'(fruit_x);      p_fy = int'(fruit_y);
         p_len = int'(snake_length); p_dead = collision_detected;
         for (int i = 0; i < 14; i++) begin
            p_bx[i] = int'(tb_bx[i]);
            p_by[i] = int'(tb_by[i]);
         end
         m_k = 0;
         exp_bi = 0;
         if (p_len < 2) begin
            model_commit();
            m_busy = 1'b0;
         end else begin
            m_busy = 1'b1;
         end
      end else if (m_busy) begin
         m_k++;
         if (m_k == p_len) begin
            model_commit();
            m_busy = 1'b0;
            exp_bi = 0;
         end else if (m_k <= p_len - 2) begin
            exp_bi = m_k;
         end else begin
            exp_bi = p_len - 2;
         end
      end else begin
         exp_bi = 0;
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_busy = 1'b0; m_dead = 1'b0;
      m_n = 0; m_hx = 0; m_hy = 0; m_fx = 0; m_fy = 0;
      exp_bi = 0;
   endtask

   task automatic step(input int x, input int y, input logic de, input logic tik);
      sb_item_t it;
      @(negedge clock_25);
      check_val("body_index", 32'(body_index), 32'(exp_bi));
      if (sb_q.size() >= 2) begin
         it = sb_q.pop_front();
         check_val("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(it.rgb));
         check_val("sync", 32'({VGA_HS, VGA_VS}), 32'(it.sync));
      end
      snake_body_x = tb_bx[prev_bi];
      snake_body_y = tb_by[prev_bi];
      prev_bi      = body_index;
      X            = 10'(x);
      Y            = 10'(y);
      display_area = de;
      h_sync       = 1'($urandom_range(0, 1));
      v_sync       = 1'($urandom_range(0, 1));
      frame_tik    = tik;
      model_edge(tik);
      it.rgb  = de ? model_col(x, y) : 12'h000;
      it.sync = {h_sync, v_sync};
      sb_q.push_back(it);
   endtask

   task automatic pix(input int x, input int y);
      step(x, y, 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 1'b0, 1'b0);
   endtask

   task automatic tik();
      step(0, 0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      sb_item_t z;
      reset = 1'b1; frame_tik = 1'b0; display_area = 1'b1;
      h_sync = 1'b1; v_sync = 1'b1; X = 10'd0; Y = 10'd0;
      repeat (3) begin
         @(negedge clock_25);
         check_val("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
         check_val("rst_sync", 32'({VGA_HS, VGA_VS}), 32'h0);
         check_val("rst_bi", 32'(body_index), 32'h0);
      end
      reset = 1'b0;
      display_area = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
      model_reset();
      prev_bi = 4'd0;
      sb_q.delete();
      z.rgb = 12'h000; z.sync = 2'b00;
      sb_q.push_back(z);   // stage 2 as cleared by reset
      sb_q.push_back(z);   // inputs driven on the release cycle
   endtask

   task automatic set_snake(input int hx, input int hy, input int fx, input int fy,
                            input int len, input bit dead);
      snake_head_x = 7'(hx); snake_head_y = 7'(hy);
      fruit_x = 7'(fx); fruit_y = 7'(fy);
      snake_length = 4'(len); collision_detected = dead;
   endtask

   task automatic set_body_row(input int x0, input int dx, input int y);
      for (int i = 0; i < 16; i++) begin
         tb_bx[i] = 7'(x0 + dx * i);
         tb_by[i] = 7'(y);
      end
   endtask

   initial begin
      X = 10'd0; Y = 10'd0; display_area = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
      frame_tik = 1'b0; snake_body_x = 7'd0; snake_body_y = 7'd0; prev_bi = 4'd0;
      set_snake(0, 0, 0, 0, 0, 1'b0);
      set_body_row(0, 0, 0);
      do_reset();

      // no snapshot yet: border and background only, grid edge boundaries
      pix(320, 240); pix(0, 0); pix(639, 479); pix(632, 100);
      pix(640, 0); pix(0, 480); pix(8, 8); step(0, 0, 1'b0, 1'b0);

      // length 4; probe the head pixel every cycle to pin the commit cycle
      set_snake(10, 5, 20, 20, 4, 1'b0);
      set_body_row(9, -1, 5);
      step(80, 40, 1'b1, 1'b1);
      repeat (6) pix(80, 40);
      pix(72, 40); pix(64, 40); pix(56, 40); pix(48, 40); pix(160, 160); pix(163, 167);

      // fruit under a body segment, head on the border corner
      set_snake(0, 0, 9, 5, 4, 1'b0);
      tik(); idle(6);
      pix(72, 40); pix(0, 0); pix(7, 7); pix(160, 160);

      // game over: head drawn red
      set_snake(10, 5, 20, 20, 4, 1'b1);
      tik(); idle(6);
      pix(80, 40); pix(72, 40);

      // head-only snake wipes the stale body
      set_snake(30, 30, 20, 20, 1, 1'b0);
      tik(); idle(3);
      pix(240, 240); pix(72, 40); pix(160, 160);

      // restart mid-fetch: only the second latch may be committed
      set_snake(10, 5, 20, 20, 4, 1'b0);
      set_body_row(11, 1, 5);
      tik(); idle(1);
      set_snake(40, 40, 50, 50, 4, 1'b0);
      set_body_row(41, 1, 40);
      tik(); idle(6);
      pix(320, 320); pix(328, 320); pix(344, 320); pix(352, 320);
      pix(88, 40); pix(80, 40); pix(400, 400);

      // full capacity: 14 body entries
      set_snake(19, 30, 60, 10, 15, 1'b0);
      set_body_row(20, 1, 30);
      tik(); idle(16);
      pix(160, 240); pix(264, 240); pix(272, 240); pix(152, 240); pix(480, 80);

      // reset in the middle of a fetch, then a clean frame
      set_snake(5, 5, 6, 6, 15, 1'b0);
      tik(); idle(3);
      do_reset();
      pix(264, 240); pix(40, 40); pix(0, 0);
      set_snake(2, 2, 30, 3, 2, 1'b0);
      set_body_row(3, 1, 2);
      tik(); idle(4);
      pix(16, 16); pix(24, 16); pix(32, 16); pix(240, 24);

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
